// File: rtl/stepper_move_sequencer_if.sv
// Command push and driver start/busy signals shared by stepper_move_sequencer and its environment.
interface stepper_move_sequencer_if;
    // A command transfers on a rising edge where i_cmd_valid and o_cmd_ready are both high.
    // o_cmd_ready never depends on i_cmd_valid. A driver move starts on a one-cycle
    // o_drv_start and completes when i_drv_busy rises and then falls.
    logic        i_cmd_valid;
    logic        i_cmd_dir;
    logic [23:0] i_cmd_pulses;
    logic [15:0] i_cmd_dwell;
    logic        o_cmd_ready;
    logic        o_drv_start;
    logic        o_drv_dir;
    logic [23:0] o_drv_pulses;
    logic        o_drv_rst;
    logic        i_drv_busy;

    modport slave (
        input  i_cmd_valid, i_cmd_dir, i_cmd_pulses, i_cmd_dwell, i_drv_busy,
        output o_cmd_ready, o_drv_start, o_drv_dir, o_drv_pulses, o_drv_rst
    );

    modport master (
        output i_cmd_valid, i_cmd_dir, i_cmd_pulses, i_cmd_dwell, i_drv_busy,
        input  o_cmd_ready, o_drv_start, o_drv_dir, o_drv_pulses, o_drv_rst
    );
endinterface

// File: rtl/stepper_move_sequencer.sv
// Queues stepper moves in a small FIFO and plays them one at a time into the pulse driver.
// Define STEPPER_SEQ_POSITION_EN for signed position tracking and the i_pos_zero input.
module stepper_move_sequencer #(
    parameter int FIFO_AW      = 2,
    parameter int ACK_TIMEOUT  = 8,
    parameter int ABORT_CYCLES = 2
) (
    input  logic                    i_clk_100k,
    input  logic                    i_rst,
    stepper_move_sequencer_if.slave seq_bus,
    input  logic                    i_abort,
`ifdef STEPPER_SEQ_POSITION_EN
    input  logic                    i_pos_zero,
`endif
    output logic                    o_busy,
    output logic [FIFO_AW:0]        o_fifo_count,
    output logic [15:0]             o_moves_done,
    output logic                    o_err_timeout,
    output logic [31:0]             o_position,
    output logic                    o_pos_valid,
    output logic [2:0]              o_state
);
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_ACK  = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_DWELL     = 3'd4;
    localparam logic [2:0] S_ABORT     = 3'd5;

    logic [40:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic [2:0]         r_state;
    logic [15:0]        r_tmr;
    logic               r_drv_dir;
    logic [23:0]        r_drv_pulses;
    logic [15:0]        r_dwell;
    logic [15:0]        r_moves_done;
    logic               r_err_timeout;

    logic        w_full;
    logic        w_ready;
    logic        w_push;
    logic        w_pop;
    logic        w_retire;
    logic [40:0] w_head;

    // Abort wins over every push, pop and retire in the cycle it is seen.
    assign w_full   = (r_count == (FIFO_AW+1)'(DEPTH));
    assign w_ready  = !w_full && (r_state != S_ABORT);
    assign w_push   = seq_bus.i_cmd_valid && w_ready && !i_abort;
    assign w_pop    = (r_state == S_IDLE) && (r_count != '0) && !i_abort;
    assign w_head   = r_mem[r_rd_ptr];
    assign w_retire = !i_abort &&
                      (((r_state == S_ISSUE) && (r_drv_pulses == '0)) ||
                       ((r_state == S_WAIT_DONE) && !seq_bus.i_drv_busy));

    always_ff @(posedge i_clk_100k) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {seq_bus.i_cmd_dir, seq_bus.i_cmd_pulses, seq_bus.i_cmd_dwell};
                r_wr_ptr        <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (FIFO_AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (FIFO_AW+1)'(1);
            end
        end
    end

    // r_tmr is shared: ack timeout in WAIT_ACK, dwell count in DWELL, hold time in ABORT.
    always_ff @(posedge i_clk_100k) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_tmr         <= '0;
            r_drv_dir     <= 1'b0;
            r_drv_pulses  <= '0;
            r_dwell       <= '0;
            r_moves_done  <= '0;
            r_err_timeout <= 1'b0;
        end else if (i_abort) begin
            r_state       <= S_ABORT;
            r_tmr         <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_retire) begin
                r_moves_done <= r_moves_done + 16'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state                              <= S_ISSUE;
                        {r_drv_dir, r_drv_pulses, r_dwell}   <= w_head;
                    end
                end
                S_ISSUE: begin
                    r_tmr   <= '0;
                    r_state <= (r_drv_pulses != '0) ? S_WAIT_ACK : S_DWELL;
                end
                S_WAIT_ACK: begin
                    if (seq_bus.i_drv_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_tmr == 16'(ACK_TIMEOUT - 1)) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_tmr <= r_tmr + 16'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!seq_bus.i_drv_busy) begin
                        r_tmr   <= '0;
                        r_state <= S_DWELL;
                    end
                end
                S_DWELL: begin
                    if ((r_dwell == '0) || (r_tmr == r_dwell - 16'd1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_tmr <= r_tmr + 16'd1;
                    end
                end
                S_ABORT: begin
                    if (r_tmr == 16'(ABORT_CYCLES - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_tmr <= r_tmr + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef STEPPER_SEQ_POSITION_EN
    logic [31:0] r_position;
    logic        r_pos_valid;
    logic [31:0] w_delta;

    assign w_delta = {8'd0, r_drv_pulses};

    // An abort mid-move leaves the motor somewhere inside the move, so the count is no longer trusted.
    always_ff @(posedge i_clk_100k) begin
        if (i_rst) begin
            r_position  <= '0;
            r_pos_valid <= 1'b1;
        end else if (i_abort) begin
            if ((r_state == S_WAIT_ACK) || (r_state == S_WAIT_DONE)) begin
                r_pos_valid <= 1'b0;
            end
        end else if (w_retire) begin
            r_position <= r_drv_dir ? (r_position + w_delta) : (r_position - w_delta);
        end else if ((r_state == S_IDLE) && i_pos_zero) begin
            r_position  <= '0;
            r_pos_valid <= 1'b1;
        end
    end

    assign o_position  = r_position;
    assign o_pos_valid = r_pos_valid;
`else
    assign o_position  = '0;
    assign o_pos_valid = 1'b0;
`endif

    assign seq_bus.o_cmd_ready  = w_ready;
    assign seq_bus.o_drv_start  = (r_state == S_ISSUE) && (r_drv_pulses != '0);
    assign seq_bus.o_drv_dir    = r_drv_dir;
    assign seq_bus.o_drv_pulses = r_drv_pulses;
    assign seq_bus.o_drv_rst    = i_rst || (r_state == S_ABORT);

    assign o_busy        = (r_state != S_IDLE) || (r_count != '0);
    assign o_fifo_count  = r_count;
    assign o_moves_done  = r_moves_done;
    assign o_err_timeout = r_err_timeout;
    assign o_state       = r_state;
endmodule
